// File: rtl/async_fifo_pkg.sv
// Shared dual-clock FIFO package: pointer-width rule and Gray/binary helpers.
// Used by the write-side controller, the read-side controller and benches.
// Helpers work on zero-extended values up to CODE_W bits. This makes them
// width-agnostic: zero upper bits do not disturb the Gray <-> binary prefix.
package async_fifo_pkg;

   localparam int unsigned CODE_W = 32;

   // Pointer carries one wrap bit above the memory address.
   function automatic int unsigned ptr_w(input int unsigned addr_width);
      return addr_width + 1;
   endfunction

   function automatic logic [CODE_W-1:0] bin2gray(input logic [CODE_W-1:0] bin);
      return bin ^ (bin >> 1);
   endfunction

   // XOR-prefix from the MSB down.
   function automatic logic [CODE_W-1:0] gray2bin(input logic [CODE_W-1:0] gray);
      logic [CODE_W-1:0] bin;
      bin[CODE_W-1] = gray[CODE_W-1];
      for (int i = CODE_W - 2; i >= 0; i--) begin
         bin[i] = bin[i+1] ^ gray[i];
      end
      return bin;
   endfunction

endpackage

// File: rtl/async_fifo_wr_ctrl_if.sv
// Write-domain bus of the dual-clock FIFO controller.
// Optional macro ASYNC_FIFO_WR_LEVEL_EN adds WR_LEVEL and ALMOST_FULL.
// Signals:
//   W_INC        producer write request
//   SYNC_RD_PTR  Gray read pointer, already synchronized into the write clock
//   WR_EN        memory write enable
//   WR_ADDR      memory write address
//   WR_PTR       registered Gray write pointer for the pointer synchronizer
//   FULL         registered full flag
//   WR_LEVEL     fill level (macro only)
//   ALMOST_FULL  level at/above threshold (macro only)
// The master modport is the producer side. The slave modport is the controller.
interface async_fifo_wr_ctrl_if
   import async_fifo_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH = 3
);
   localparam int unsigned PTR_W = ptr_w(ADDR_WIDTH);

   logic                  W_INC;
   logic [PTR_W-1:0]      SYNC_RD_PTR;
   logic                  WR_EN;
   logic [ADDR_WIDTH-1:0] WR_ADDR;
   logic [PTR_W-1:0]      WR_PTR;
   logic                  FULL;
`ifdef ASYNC_FIFO_WR_LEVEL_EN
   logic [PTR_W-1:0]      WR_LEVEL;
   logic                  ALMOST_FULL;

   modport master (
      output W_INC, SYNC_RD_PTR,
      input  WR_EN, WR_ADDR, WR_PTR, FULL, WR_LEVEL, ALMOST_FULL
   );

   modport slave (
      input  W_INC, SYNC_RD_PTR,
      output WR_EN, WR_ADDR, WR_PTR, FULL, WR_LEVEL, ALMOST_FULL
   );
`else
   modport master (
      output W_INC, SYNC_RD_PTR,
      input  WR_EN, WR_ADDR, WR_PTR, FULL
   );

   modport slave (
      input  W_INC, SYNC_RD_PTR,
      output WR_EN, WR_ADDR, WR_PTR, FULL
   );
`endif

endinterface

// File: rtl/gray2bin_conv.sv
// Combinational Gray-to-binary converter (XOR prefix from the MSB).
// Ports:
//   gray  in  W  Gray-coded value
//   bin   out W  binary equivalent
module gray2bin_conv #(
   parameter int unsigned W = 4
) (
   input  logic [W-1:0] gray,
   output logic [W-1:0] bin
);

   // Each binary bit is the parity of this Gray bit and all bits above it.
   for (genvar i = 0; i < W; i++) begin : g_bit
      assign bin[i] = ^gray[W-1:i];
   end

endmodule

// File: rtl/async_fifo_wr_ctrl.sv
// Write-domain controller of the dual-clock FIFO.
// - Owns the binary and Gray write pointers.
// - Drives the memory write enable and address.
// - Publishes the registered Gray pointer and derives FULL from the
//   synchronized read pointer.
// Optional macro ASYNC_FIFO_WR_LEVEL_EN adds registered WR_LEVEL/ALMOST_FULL.
// Ports:
//   CLK  in   write-domain clock
//   RST  in   asynchronous active-low reset
//   bus  slave modport of async_fifo_wr_ctrl_if
//        (W_INC, SYNC_RD_PTR in; WR_EN, WR_ADDR, WR_PTR, FULL
//        [, WR_LEVEL, ALMOST_FULL] out)
module async_fifo_wr_ctrl
   import async_fifo_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH   = 3,
   parameter int unsigned AFULL_THRESH = 6
) (
   input logic                 CLK,
   input logic                 RST,
   async_fifo_wr_ctrl_if.slave bus
);

   localparam int unsigned PTR_W = ptr_w(ADDR_WIDTH);

   // Elaboration-time parameter sanity.
   if (ADDR_WIDTH < 2) begin : g_bad_addr_width
      $error("async_fifo_wr_ctrl: ADDR_WIDTH must be >= 2");
   end
   if ((AFULL_THRESH < 1) || (AFULL_THRESH > (32'd1 << ADDR_WIDTH))) begin : g_bad_afull
      $error("async_fifo_wr_ctrl: AFULL_THRESH out of range 1..2**ADDR_WIDTH");
   end

   logic [PTR_W-1:0] bin_q;
   logic [PTR_W-1:0] gray_q;
   logic             full_q;

   logic             wr_en;
   logic [PTR_W-1:0] bin_next;
   logic [PTR_W-1:0] gray_next;
   logic [PTR_W-1:0] rd_full_pat;
   logic             full_next;

   // A write is accepted only out of reset and while not full.
   assign wr_en = bus.W_INC & ~full_q & RST;

   // Next pointer and full detection. Full is reached when the write pointer
   // sits one wrap ahead of the read pointer: the top two Gray bits are
   // inverted and the rest are equal.
   always_comb begin
      bin_next    = bin_q + PTR_W'(wr_en);
      gray_next   = PTR_W'(bin2gray(CODE_W'(bin_next)));
      rd_full_pat = {~bus.SYNC_RD_PTR[PTR_W-1 -: 2], bus.SYNC_RD_PTR[PTR_W-3:0]};
      full_next   = (gray_next == rd_full_pat);
   end

   // Pointer and flag registers.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         bin_q  <= '0;
         gray_q <= '0;
         full_q <= 1'b0;
      end else begin
         bin_q  <= bin_next;
         gray_q <= gray_next;
         full_q <= full_next;
      end
   end

   assign bus.WR_EN   = wr_en;
   assign bus.WR_ADDR = bin_q[ADDR_WIDTH-1:0];
   assign bus.WR_PTR  = gray_q;
   assign bus.FULL    = full_q;

`ifdef ASYNC_FIFO_WR_LEVEL_EN
   logic [PTR_W-1:0] rd_bin;
   logic [PTR_W-1:0] level_next;
   logic             afull_next;
   logic [PTR_W-1:0] level_q;
   logic             afull_q;

   gray2bin_conv #(
      .W(PTR_W)
   ) u_rd_gray2bin (
      .gray(bus.SYNC_RD_PTR),
      .bin (rd_bin)
   );

   // Modular difference stays in 0..2**ADDR_WIDTH for legal pointers.
   always_comb begin
      level_next = bin_next - rd_bin;
      afull_next = (CODE_W'(level_next) >= AFULL_THRESH);
   end

   // Level registers share FULL's timing.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         level_q <= '0;
         afull_q <= 1'b0;
      end else begin
         level_q <= level_next;
         afull_q <= afull_next;
      end
   end

   assign bus.WR_LEVEL    = level_q;
   assign bus.ALMOST_FULL = afull_q;
`endif

endmodule

// File: tb/tb_async_fifo_wr_ctrl.sv
// Scoreboard bench for async_fifo_wr_ctrl: each stimulus cycle queues the
// hand-computed mid-cycle response; a monitor pops and compares on negedge.
module tb_async_fifo_wr_ctrl;
   import async_fifo_pkg::*;

   localparam int unsigned AW = 3;
   localparam int unsigned PW = ptr_w(AW);

   // 4-bit Gray sequence, hand-written.
   localparam logic [3:0] GRAY [16] = '{
      4'b0000, 4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0111, 4'b0101, 4'b0100,
      4'b1100, 4'b1101, 4'b1111, 4'b1110, 4'b1010, 4'b1011, 4'b1001, 4'b1000
   };

   typedef struct {
      int            id;
      logic          en;
      logic [AW-1:0] addr;
      logic [PW-1:0] ptr;
      logic          full;
      logic          chk_lvl;
      logic [PW-1:0] lvl;
      logic          afull;
   } exp_t;

   logic CLK = 1'b0;
   logic RST;
   exp_t q[$];
   int   checks  = 0;
   int   errors  = 0;
   int   step_id = 0;

   async_fifo_wr_ctrl_if #(.ADDR_WIDTH(AW)) bus ();

   async_fifo_wr_ctrl #(
      .ADDR_WIDTH  (AW),
      .AFULL_THRESH(6)
   ) dut (
      .CLK(CLK),
      .RST(RST),
      .bus(bus)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input int id, input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL step %0d %s: got %0h expected %0h", id, name, act, exp);
      end
   endtask

   // Monitor: compares the DUT's mid-cycle outputs against the queued expectation.
   initial begin
      exp_t e;
      forever begin
         @(negedge CLK);
         if (q.size() > 0) begin
            e = q.pop_front();
            chk(e.id, "WR_EN",   32'(bus.WR_EN),   32'(e.en));
            chk(e.id, "WR_ADDR", 32'(bus.WR_ADDR), 32'(e.addr));
            chk(e.id, "WR_PTR",  32'(bus.WR_PTR),  32'(e.ptr));
            chk(e.id, "FULL",    32'(bus.FULL),    32'(e.full));
`ifdef ASYNC_FIFO_WR_LEVEL_EN
            if (e.chk_lvl) begin
               chk(e.id, "WR_LEVEL",    32'(bus.WR_LEVEL),    32'(e.lvl));
               chk(e.id, "ALMOST_FULL", 32'(bus.ALMOST_FULL), 32'(e.afull));
            end
`endif
         end
      end
   end

   task automatic stepl(input logic rst, input logic w, input logic [PW-1:0] rp,
                        input logic en, input logic [AW-1:0] a, input logic [PW-1:0] p,
                        input logic f, input logic cl, input logic [PW-1:0] lv,
                        input logic af);
      exp_t e;
      @(posedge CLK);
      #1;
      RST             = rst;
      bus.W_INC       = w;
      bus.SYNC_RD_PTR = rp;
      e.id      = step_id;
      e.en      = en;
      e.addr    = a;
      e.ptr     = p;
      e.full    = f;
      e.chk_lvl = cl;
      e.lvl     = lv;
      e.afull   = af;
      q.push_back(e);
      step_id++;
   endtask

   task automatic step(input logic rst, input logic w, input logic [PW-1:0] rp,
                       input logic en, input logic [AW-1:0] a, input logic [PW-1:0] p,
                       input logic f);
      stepl(rst, w, rp, en, a, p, f, 1'b0, '0, 1'b0);
   endtask

   initial begin
      #50000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      RST             = 1'b0;
      bus.W_INC       = 1'b1;
      bus.SYNC_RD_PTR = '0;

      // Reset held with a pending request: nothing is accepted.
      step(1'b0, 1'b1, 4'b0000, 1'b0, 3'd0, 4'b0000, 1'b0);
      step(1'b0, 1'b1, 4'b0000, 1'b0, 3'd0, 4'b0000, 1'b0);
      // Idle after reset.
      for (int k = 0; k < 5; k++)
         step(1'b1, 1'b0, 4'b0000, 1'b0, 3'd0, 4'b0000, 1'b0);

      // Fill: 8 writes accepted, FULL on the 8th, 9th dropped.
      for (int k = 0; k < 9; k++)
         step(1'b1, 1'b1, 4'b0000, 1'(k < 8), 3'(k), GRAY[k], 1'(k == 8));
      step(1'b1, 1'b0, 4'b0000, 1'b0, 3'd0, 4'b1100, 1'b1);

      // Drain release: read pointer advances, FULL clears one cycle later.
      step(1'b1, 1'b0, 4'b0001, 1'b0, 3'd0, 4'b1100, 1'b1);
      step(1'b1, 1'b1, 4'b0001, 1'b1, 3'd0, 4'b1100, 1'b0);
      step(1'b1, 1'b1, 4'b0001, 1'b0, 3'd1, 4'b1101, 1'b1);
      step(1'b1, 1'b0, 4'b0001, 1'b0, 3'd1, 4'b1101, 1'b1);

      // Asynchronous reset from a full state.
      step(1'b0, 1'b0, 4'b0000, 1'b0, 3'd0, 4'b0000, 1'b0);

      // Wrap: 16 writes, read pointer 2 behind, FULL never asserts.
      for (int k = 0; k < 16; k++)
         step(1'b1, 1'b1, GRAY[(k + 14) % 16], 1'b1, 3'(k), GRAY[k], 1'b0);
      step(1'b1, 1'b0, GRAY[14], 1'b0, 3'd0, 4'b0000, 1'b0);

      // Reset mid-operation after 5 writes.
      for (int k = 0; k < 5; k++)
         step(1'b1, 1'b1, 4'b0000, 1'b1, 3'(k), GRAY[k], 1'b0);
      step(1'b1, 1'b0, 4'b0000, 1'b0, 3'd5, 4'b0111, 1'b0);
      step(1'b0, 1'b1, 4'b0000, 1'b0, 3'd0, 4'b0000, 1'b0);
      step(1'b1, 1'b1, 4'b0000, 1'b1, 3'd0, 4'b0000, 1'b0);
      step(1'b1, 1'b0, 4'b0000, 1'b0, 3'd1, 4'b0001, 1'b0);

      // Level: 6 writes against read pointer 0, then read pointer to binary 2.
      stepl(1'b0, 1'b0, 4'b0000, 1'b0, 3'd0, 4'b0000, 1'b0, 1'b1, 4'd0, 1'b0);
      for (int k = 0; k < 6; k++)
         stepl(1'b1, 1'b1, 4'b0000, 1'b1, 3'(k), GRAY[k], 1'b0, 1'b1, 4'(k), 1'b0);
      stepl(1'b1, 1'b0, 4'b0000, 1'b0, 3'd6, 4'b0101, 1'b0, 1'b1, 4'd6, 1'b1);
      stepl(1'b1, 1'b0, 4'b0011, 1'b0, 3'd6, 4'b0101, 1'b0, 1'b1, 4'd6, 1'b1);
      stepl(1'b1, 1'b0, 4'b0011, 1'b0, 3'd6, 4'b0101, 1'b0, 1'b1, 4'd4, 1'b0);

      // Let the monitor drain the queue, bounded.
      @(negedge CLK);
      #1;
      for (int i = 0; i < 10 && q.size() != 0; i++) @(negedge CLK);
      checks++;
      if (q.size() != 0) begin
         errors++;
         $display("FAIL drain: got %0d pending expected 0", q.size());
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/async_fifo_wr_ctrl.md
Name: async_fifo_wr_ctrl

Overview:
- Write-domain controller of the team's dual-clock FIFO.
- Owns the write pointer (binary and Gray) and drives the FIFO memory write enable and address.
- Publishes the registered Gray write pointer, which the 2-flop pointer synchronizer carries into the read domain.
- Takes the read pointer after the mirror synchronizer has brought it into CLK's domain, and uses it to generate FULL. The optional feature also generates fill level and almost-full.

Parameters:
- ADDR_WIDTH, 3, memory address width; depth = 2**ADDR_WIDTH; must be >= 2; pointer width = ADDR_WIDTH+1 (default 4).
- AFULL_THRESH, 6, fill level at or above which ALMOST_FULL asserts; range 1..2**ADDR_WIDTH (used only with the optional feature).

Ports:
- CLK  in  1  write-domain clock.
- RST  in  1  asynchronous, active-low reset.
- W_INC  in  1  write request from the producer.
- SYNC_RD_PTR  in  ADDR_WIDTH+1  Gray read pointer, already synchronized into CLK.
- WR_EN  out  1  memory write enable.
- WR_ADDR  out  ADDR_WIDTH  memory write address.
- WR_PTR  out  ADDR_WIDTH+1  registered Gray write pointer, sent to the synchronizer.
- FULL  out  1  registered full flag.
- WR_LEVEL  out  ADDR_WIDTH+1  fill level (optional feature only).
- ALMOST_FULL  out  1  level >= AFULL_THRESH (optional feature only).

Behaviour:
- Reset (RST low, asynchronous): binary pointer = 0, WR_PTR = 0, FULL = 0, WR_LEVEL = 0, ALMOST_FULL = 0. Reset mid-operation discards all pointer state immediately. No write is accepted while RST is low.
- Write acceptance: WR_EN = W_INC & ~FULL, combinational. A request while FULL = 1 is dropped: pointer holds and WR_EN = 0.
- WR_ADDR = binary pointer[ADDR_WIDTH-1:0], taken straight from the register (no logic). The accepted word is written at the current address; the pointer advances on the same CLK edge.
- Next-state logic:
  - bin_next = bin + WR_EN, modulo 2**(ADDR_WIDTH+1); natural wrap, no saturation.
  - gray_next = bin_next ^ (bin_next >> 1).
  - WR_PTR <= gray_next. It is a flop output only, so at most one bit changes per cycle (synchronizer-safe).
- Full detection:
  - full_next = (gray_next == {~SYNC_RD_PTR[MSB:MSB-1], SYNC_RD_PTR[MSB-2:0]}), with MSB = ADDR_WIDTH.
  - FULL <= full_next.
  - FULL asserts on the same edge that accepts the 2**ADDR_WIDTH-th unread word.
  - FULL deasserts one CLK after SYNC_RD_PTR advances. It is pessimistic by the synchronizer latency; this is intended.
- Simultaneous write and read-pointer change: both use the same-cycle values in full_next. There is no hazard, because SYNC_RD_PTR is stable within a CLK cycle.
- SYNC_RD_PTR is treated as a legal Gray value. There is no checking of the read pointer running ahead.

Optional Feature:
- Macro: ASYNC_FIFO_WR_LEVEL_EN.
- Defined:
  - rd_bin = gray2bin(SYNC_RD_PTR).
  - WR_LEVEL <= bin_next - rd_bin (modulo 2**(ADDR_WIDTH+1), range 0..2**ADDR_WIDTH).
  - ALMOST_FULL <= (bin_next - rd_bin) >= AFULL_THRESH.
  - Both are registered, reset to 0, and have the same timing as FULL.
- Undefined: WR_LEVEL and ALMOST_FULL ports and their logic are absent. The remaining behaviour is identical.

Decomposition:
- Shared package async_fifo_pkg holds:
  - bin2gray and gray2bin functions, parameterized by width.
  - Pointer-width constant rule PTR_W = ADDR_WIDTH+1.
  - The read-side controller and the testbench also use this package.
- One natural sub-module: gray2bin_conv, a combinational XOR-prefix converter. It is instantiated only under ASYNC_FIFO_WR_LEVEL_EN.

Test Plan:
- Reset/idle: RST low, then high, W_INC = 0 for 5 cycles -> WR_PTR = 0000, WR_ADDR = 0, FULL = 0, WR_EN = 0 throughout.
- Fill:
  - Stimulus: SYNC_RD_PTR = 0000, W_INC = 1 for 9 cycles.
  - WR_ADDR sequence: 0..7.
  - WR_PTR sequence: 0001, 0011, 0010, 0110, 0111, 0101, 0100, 1100.
  - FULL = 1 on the edge accepting the 8th write.
  - 9th request: WR_EN = 0, WR_PTR stays 1100.
- Drain release:
  - Stimulus: from full, SYNC_RD_PTR goes 0000 -> 0001, W_INC = 0.
  - FULL = 0 one cycle later.
  - A following write is accepted at WR_ADDR = 0, WR_PTR = 1101, and FULL re-asserts.
- Wrap:
  - Stimulus: 16 writes, with SYNC_RD_PTR tracking 2 behind in Gray.
  - Response: WR_PTR returns to 0000, WR_ADDR wraps 7 -> 0, FULL never asserts.
- Reset mid-operation: after 5 writes (WR_PTR = 0111), pulse RST low asynchronously -> WR_PTR = 0000 and FULL = 0 immediately; the next write uses WR_ADDR = 0.
- Level (macro defined, AFULL_THRESH = 6, SYNC_RD_PTR = 0000):
  - After 6 writes: WR_LEVEL = 6, ALMOST_FULL = 1.
  - Then SYNC_RD_PTR = 0011 (binary 2): WR_LEVEL = 4, ALMOST_FULL = 0, one cycle later.
